// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   Decides each cycle how many of the two head instructions of the issue
//   buffer are sent to dispatch (0, 1 or 2). A per-register scoreboard of
//   2-bit latency counters blocks RAW/WAW hazards against in-flight results.
//   Intra-pair hazards, the single memory port, the single branch unit and
//   barrier draining are also enforced here.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_is_valid[1:0]          bit1 = slot a (older) valid, bit0 = slot b valid
//   a_* / b_*                register addresses, source-use flags, rd write
//                            enable and class flags (load, mem, branch, barrier)
//   stall_DCache             DCache miss: no issue, scoreboard frozen
//   flush_BR                 mispredict flush: no issue, FSM back to RUN
//   o_usingNUM               instructions consumed this cycle
//   o_issue_a, o_issue_b     per-slot issue strobes (combinational)
//   o_busy_vec               bit r set while register r has a pending result
//   o_state                  0 = RUN, 1 = DRAIN
//   o_stall_cnt              saturating count of cycles slot a sat unissued
module dual_issue_scheduler #(
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       i_is_valid,
  input  logic [4:0]       a_rs1,
  input  logic [4:0]       a_rs2,
  input  logic [4:0]       a_rd,
  input  logic             a_rs1_use,
  input  logic             a_rs2_use,
  input  logic             a_we,
  input  logic             a_is_load,
  input  logic             a_is_mem,
  input  logic             a_is_br,
  input  logic             a_is_bar,
  input  logic [4:0]       b_rs1,
  input  logic [4:0]       b_rs2,
  input  logic [4:0]       b_rd,
  input  logic             b_rs1_use,
  input  logic             b_rs2_use,
  input  logic             b_we,
  input  logic             b_is_load,
  input  logic             b_is_mem,
  input  logic             b_is_br,
  input  logic             b_is_bar,
  input  logic             stall_DCache,
  input  logic             flush_BR,
  output logic [1:0]       o_usingNUM,
  output logic             o_issue_a,
  output logic             o_issue_b,
  output logic [31:0]      o_busy_vec,
  output logic             o_state,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  // A counter loaded with LAT-1 at the issue edge reaches zero exactly LAT
  // cycles after issue, which is when a dependent may go.
  localparam logic [1:0] LD_INIT  = 2'(LOAD_LAT - 1);
  localparam logic [1:0] ALU_INIT = 2'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic [1:0]       cnt_q [1:31];
  logic [CNT_W-1:0] stall_cnt_q;

  logic       any_busy;
  logic       a_wr, b_wr;
  logic       a_src_ok, b_src_ok;
  logic       a_bar_ok;
  logic       b_raw, b_waw, b_pair_ok;
  logic       issue_a, issue_b;
  logic [1:0] init_a, init_b;

  // r0 has no counter, so its busy bit is constant 0 and it always reads ready.
  always_comb begin
    o_busy_vec = '0;
    for (int r = 1; r < 32; r++) o_busy_vec[r] = |cnt_q[r];
  end

  assign any_busy = |o_busy_vec;
  assign a_wr     = a_we && (a_rd != 5'd0);
  assign b_wr     = b_we && (b_rd != 5'd0);

  assign a_src_ok = !(a_rs1_use && o_busy_vec[a_rs1]) &&
                    !(a_rs2_use && o_busy_vec[a_rs2]) &&
                    !(a_we      && o_busy_vec[a_rd]);
  assign b_src_ok = !(b_rs1_use && o_busy_vec[b_rs1]) &&
                    !(b_rs2_use && o_busy_vec[b_rs2]) &&
                    !(b_we      && o_busy_vec[b_rd]);

  // A barrier (or anything sitting in DRAIN) waits for an empty scoreboard.
  assign a_bar_ok = (state_q == DRAIN || a_is_bar) ? !any_busy : 1'b1;

  assign b_raw = a_wr && ((b_rs1_use && (b_rs1 == a_rd)) ||
                          (b_rs2_use && (b_rs2 == a_rd)));
  assign b_waw = a_wr && b_we && (b_rd == a_rd);
  assign b_pair_ok = !b_raw && !b_waw &&
                     !(a_is_mem && b_is_mem) && !(a_is_br && b_is_br) &&
                     !a_is_bar && !b_is_bar;

  assign issue_a = !rst && i_is_valid[1] && !stall_DCache && !flush_BR &&
                   a_src_ok && a_bar_ok;
  assign issue_b = issue_a && i_is_valid[0] && b_src_ok && b_pair_ok;

  assign o_issue_a   = issue_a;
  assign o_issue_b   = issue_b;
  assign o_usingNUM  = issue_b ? 2'd2 : (issue_a ? 2'd1 : 2'd0);
  assign o_state     = (state_q == DRAIN);
  assign o_stall_cnt = stall_cnt_q;

  assign init_a = a_is_load ? LD_INIT : ALU_INIT;
  assign init_b = b_is_load ? LD_INIT : ALU_INIT;

  always_comb begin
    state_d = state_q;
    if (flush_BR) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (i_is_valid[1] && a_is_bar && (any_busy || stall_DCache)) state_d = DRAIN;
    end else begin
      if (!i_is_valid[1] || issue_a) state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard: freeze on DCache stall, otherwise load issued writers and
  // count everything else down. A load on the same edge beats the decrement.
  always_ff @(posedge clk) begin
    for (int r = 1; r < 32; r++) begin
      if (rst) begin
        cnt_q[r] <= 2'd0;
      end else if (!stall_DCache) begin
        if (issue_a && a_wr && (a_rd == 5'(r))) begin
          cnt_q[r] <= init_a;
        end else if (issue_b && b_wr && (b_rd == 5'(r))) begin
          cnt_q[r] <= init_b;
        end else if (cnt_q[r] != 2'd0) begin
          cnt_q[r] <= cnt_q[r] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (i_is_valid[1] && !flush_BR && !issue_a && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] i_is_valid;
  logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic a_rs1_use, a_rs2_use, a_we, a_is_load, a_is_mem, a_is_br, a_is_bar;
  logic b_rs1_use, b_rs2_use, b_we, b_is_load, b_is_mem, b_is_br, b_is_bar;
  logic stall_DCache, flush_BR;
  logic [1:0] o_usingNUM;
  logic o_issue_a, o_issue_b;
  logic [31:0] o_busy_vec;
  logic o_state;
  logic [CNT_W-1:0] o_stall_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: absolute cycle at which each register's result is usable.
  int ready_at [32];
  int now = 0;
  bit m_drain = 1'b0;
  int m_cnt = 0;
  int last_num = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_is_valid(i_is_valid),
    .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rd(a_rd),
    .a_rs1_use(a_rs1_use), .a_rs2_use(a_rs2_use), .a_we(a_we),
    .a_is_load(a_is_load), .a_is_mem(a_is_mem), .a_is_br(a_is_br), .a_is_bar(a_is_bar),
    .b_rs1(b_rs1), .b_rs2(b_rs2), .b_rd(b_rd),
    .b_rs1_use(b_rs1_use), .b_rs2_use(b_rs2_use), .b_we(b_we),
    .b_is_load(b_is_load), .b_is_mem(b_is_mem), .b_is_br(b_is_br), .b_is_bar(b_is_bar),
    .stall_DCache(stall_DCache), .flush_BR(flush_BR),
    .o_usingNUM(o_usingNUM), .o_issue_a(o_issue_a), .o_issue_b(o_issue_b),
    .o_busy_vec(o_busy_vec), .o_state(o_state), .o_stall_cnt(o_stall_cnt)
  );

  function automatic bit pend(input logic [4:0] r);
    return (r != 5'd0) && (ready_at[r] > now);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b0; i_is_valid = 2'b00; stall_DCache = 1'b0; flush_BR = 1'b0;
    a_rs1 = 0; a_rs2 = 0; a_rd = 0; a_rs1_use = 0; a_rs2_use = 0; a_we = 0;
    a_is_load = 0; a_is_mem = 0; a_is_br = 0; a_is_bar = 0;
    b_rs1 = 0; b_rs2 = 0; b_rd = 0; b_rs1_use = 0; b_rs2_use = 0; b_we = 0;
    b_is_load = 0; b_is_mem = 0; b_is_br = 0; b_is_bar = 0;
  endtask

  // cls = {load, mem, branch, barrier}
  task automatic set_a(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we, input logic [3:0] cls);
    a_rs1 = rs1; a_rs1_use = u1; a_rs2 = rs2; a_rs2_use = u2; a_rd = rd; a_we = we;
    {a_is_load, a_is_mem, a_is_br, a_is_bar} = cls;
  endtask

  task automatic set_b(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we, input logic [3:0] cls);
    b_rs1 = rs1; b_rs1_use = u1; b_rs2 = rs2; b_rs2_use = u2; b_rd = rd; b_we = we;
    {b_is_load, b_is_mem, b_is_br, b_is_bar} = cls;
  endtask

  // Inputs are applied just after a rising edge; this checks the cycle
  // against the model, crosses the next edge and advances the model.
  task automatic step();
    logic [31:0] eb;
    bit any, bar_ok, a_ok, b_ok, awr;
    #1;
    eb = '0;
    for (int r = 1; r < 32; r++) if (ready_at[r] > now) eb[r] = 1'b1;
    any    = (eb != 0);
    bar_ok = (m_drain || a_is_bar) ? !any : 1'b1;
    a_ok   = !rst && i_is_valid[1] && !stall_DCache && !flush_BR && bar_ok &&
             !(a_rs1_use && pend(a_rs1)) && !(a_rs2_use && pend(a_rs2)) && !(a_we && pend(a_rd));
    awr    = a_we && (a_rd != 0);
    b_ok   = a_ok && i_is_valid[0] &&
             !(b_rs1_use && pend(b_rs1)) && !(b_rs2_use && pend(b_rs2)) && !(b_we && pend(b_rd)) &&
             !(awr && b_rs1_use && b_rs1 == a_rd) && !(awr && b_rs2_use && b_rs2 == a_rd) &&
             !(awr && b_we && b_rd == a_rd) &&
             !(a_is_mem && b_is_mem) && !(a_is_br && b_is_br) && !a_is_bar && !b_is_bar;
    chk("issue_a", 32'(o_issue_a), 32'(a_ok));
    chk("issue_b", 32'(o_issue_b), 32'(b_ok));
    chk("usingNUM", 32'(o_usingNUM), 32'(int'(a_ok) + int'(b_ok)));
    chk("busy_vec", o_busy_vec, eb);
    chk("state", 32'(o_state), 32'(m_drain));
    chk("stall_cnt", 32'(o_stall_cnt), 32'(m_cnt));
    last_num = int'(o_usingNUM);
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      m_drain = 1'b0;
      m_cnt = 0;
    end else begin
      if (i_is_valid[1] && !flush_BR && !a_ok && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (flush_BR) m_drain = 1'b0;
      else if (!m_drain) m_drain = i_is_valid[1] && a_is_bar && (any || stall_DCache);
      else if (!i_is_valid[1] || a_ok) m_drain = 1'b0;
      if (stall_DCache) begin
        for (int r = 1; r < 32; r++) if (ready_at[r] > now) ready_at[r]++;
      end else begin
        if (a_ok && awr) ready_at[a_rd] = now + (a_is_load ? LOAD_LAT : ALU_LAT);
        if (b_ok && b_we && b_rd != 0) ready_at[b_rd] = now + (b_is_load ? LOAD_LAT : ALU_LAT);
      end
    end
    now++;
    #1;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("reset_busy", o_busy_vec, 32'h0);
    chk("reset_state", 32'(o_state), 32'h0);

    // Independent ALU pair
    i_is_valid = 2'b11;
    set_a(0, 0, 0, 0, 5'd3, 1, 4'b0000);
    set_b(5'd4, 1, 0, 0, 5'd5, 1, 4'b0000);
    step();
    chk("t1_pair", 32'(last_num), 32'd2);
    clr(); step();
    chk("t1_busy", o_busy_vec, 32'h0);

    // Intra-pair RAW, then b moves up to slot a
    i_is_valid = 2'b11;
    set_a(0, 0, 0, 0, 5'd3, 1, 4'b0000);
    set_b(5'd3, 1, 0, 0, 5'd6, 1, 4'b0000);
    step();
    chk("t2_raw", 32'(last_num), 32'd1);
    clr(); i_is_valid = 2'b10;
    set_a(5'd3, 1, 0, 0, 5'd6, 1, 4'b0000);
    step();
    chk("t2_next", 32'(last_num), 32'd1);

    // Load-use
    set_a(0, 0, 0, 0, 5'd7, 1, 4'b1100);
    step();
    set_a(5'd7, 1, 0, 0, 5'd8, 1, 4'b0000);
    #1;
    chk("t3_busy7", 32'(o_busy_vec[7]), 32'd1);
    step();
    chk("t3_blocked", 32'(last_num), 32'd0);
    chk("t3_stallcnt", 32'(o_stall_cnt), 32'd1);
    step();
    chk("t3_go", 32'(last_num), 32'd1);

    // Load-use with a DCache stall in the shadow
    set_a(0, 0, 0, 0, 5'd9, 1, 4'b1100);
    step();
    set_a(5'd9, 1, 0, 0, 5'd10, 1, 4'b0000);
    stall_DCache = 1'b1; step();
    chk("t4_c1", 32'(last_num), 32'd0);
    stall_DCache = 1'b0; step();
    chk("t4_c2", 32'(last_num), 32'd0);
    step();
    chk("t4_c3", 32'(last_num), 32'd1);

    // Barrier drains, then issues alone
    set_a(0, 0, 0, 0, 5'd7, 1, 4'b1100);
    step();
    i_is_valid = 2'b11;
    set_a(0, 0, 0, 0, 0, 0, 4'b0001);
    set_b(0, 0, 0, 0, 5'd11, 1, 4'b0000);
    step();
    chk("t5_drain", 32'(o_state), 32'd1);
    step();
    chk("t5_bar_alone", 32'(last_num), 32'd1);
    chk("t5_run", 32'(o_state), 32'd0);

    // Flush while draining
    i_is_valid = 2'b10;
    set_a(0, 0, 0, 0, 5'd7, 1, 4'b1100);
    step();
    set_a(0, 0, 0, 0, 0, 0, 4'b0001);
    step();
    flush_BR = 1'b1; step();
    chk("t5_flush_num", 32'(last_num), 32'd0);
    chk("t5_flush_run", 32'(o_state), 32'd0);
    flush_BR = 1'b0;

    // Structural limits: two mem ops, two branches
    i_is_valid = 2'b11;
    set_a(0, 0, 0, 0, 5'd12, 1, 4'b0100);
    set_b(0, 0, 0, 0, 5'd13, 0, 4'b0100);
    step();
    chk("t6_mem", 32'(last_num), 32'd1);
    set_a(5'd1, 1, 0, 0, 0, 0, 4'b0010);
    set_b(5'd2, 1, 0, 0, 0, 0, 4'b0010);
    step();
    chk("t6_br", 32'(last_num), 32'd1);

    // Reset in the middle of a drain with a pending register
    i_is_valid = 2'b10;
    set_a(0, 0, 0, 0, 5'd7, 1, 4'b1100);
    step();
    set_a(0, 0, 0, 0, 0, 0, 4'b0001);
    stall_DCache = 1'b1; step();
    stall_DCache = 1'b0; rst = 1'b1; step();
    chk("t6_rst_busy", o_busy_vec, 32'h0);
    chk("t6_rst_state", 32'(o_state), 32'd0);
    chk("t6_rst_cnt", 32'(o_stall_cnt), 32'd0);
    rst = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      i_is_valid   = 2'($urandom_range(0, 3));
      stall_DCache = ($urandom_range(0, 5) == 0);
      flush_BR     = ($urandom_range(0, 15) == 0);
      set_a(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0)});
      a_is_mem = a_is_mem | a_is_load;
      set_b(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            {($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0)});
      b_is_mem = b_is_mem | b_is_load;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
